// File: rtl/fir_io_pkg.sv
// fir_io_pkg: shared widths and serializer state encoding for the fir_core output path
package fir_io_pkg;
  localparam int DATA_W = 16;
  localparam int OUT_W = 8;
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} ser_state_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: synchronous register-array FIFO with extra-MSB pointers for full/empty
module fir_sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdat_i,
  output logic [W-1:0]               rdat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     lvl_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_q[AW-1:0]] <= wdat_i;
  assign rdat_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign lvl_o = wr_q - rd_q;
endmodule

// File: rtl/fir_out_serializer.sv
// fir_out_serializer: buffers fir_core results and streams each as low then high byte
module fir_out_serializer
  import fir_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             y_dat,
  input  logic                          y_vld,
  output logic [OUT_W-1:0]              out_dat,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic                          out_hi,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
  output logic [CNT_W-1:0]              ovf_cnt
);
  ser_state_t state_q, state_d;
  logic [OUT_W-1:0] dat_q, dat_d, hb_q, hb_d;
  logic vld_q, vld_d, hi_q, hi_d;
  logic [CNT_W-1:0] ovf_q;
  logic [DATA_W-1:0] rdat;
  logic pop, push, drop, full, empty;
  // a pop on the same edge frees the slot the incoming sample needs
  assign push = y_vld & (~full | pop);
  assign drop = y_vld & full & ~pop;
  fir_sample_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .wdat_i(y_dat),
    .rdat_o(rdat),
    .full_o(full),
    .empty_o(empty),
    .lvl_o(fifo_lvl)
  );
  always_comb begin
    state_d = state_q;
    dat_d = dat_q;
    hb_d = hb_q;
    vld_d = vld_q;
    hi_d = hi_q;
    pop = 1'b0;
    unique case (state_q)
      IDLE: pop = ~empty;
      SEND_LO: if (out_rdy) begin
        dat_d = hb_q;
        hi_d = 1'b1;
        state_d = SEND_HI;
      end
      SEND_HI: if (out_rdy) begin
        pop = ~empty;
        vld_d = 1'b0;
        hi_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // loading a new sample always starts at its low byte
    if (pop) begin
      dat_d = rdat[OUT_W-1:0];
      hb_d = rdat[DATA_W-1:OUT_W];
      hi_d = 1'b0;
      vld_d = 1'b1;
      state_d = SEND_LO;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dat_q <= '0;
      hb_q <= '0;
      vld_q <= 1'b0;
      hi_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      dat_q <= dat_d;
      hb_q <= hb_d;
      vld_q <= vld_d;
      hi_q <= hi_d;
      ovf_q <= ovf_q + CNT_W'(drop & ~&ovf_q);
    end
  end
  assign out_dat = dat_q;
  assign out_vld = vld_q;
  assign out_hi = hi_q;
  assign ovf_cnt = ovf_q;
endmodule
